// File: rtl/calc_sequencer.sv
// calc_sequencer: keypad-driven calculator control FSM.
// Builds operand A, the operator and operand B from decimal key entries.
// Starts the shared ALU with a start/done handshake, bounded by a timeout.
// Registers the display value, sign and error flags for the 7-segment path.
module calc_sequencer #(
   parameter int unsigned W          = 14,
   parameter int unsigned MAX_DIGITS = 4,
   parameter int unsigned TIMEOUT    = 64
) (
   input  logic         clock,
   input  logic         reset,
   input  logic [4:0]   key,
   input  logic         press,
   input  logic         alu_done,
   input  logic         alu_error,
   input  logic         alu_neg,
   input  logic [W-1:0] alu_result,
   output logic [W-1:0] operand_a,
   output logic [W-1:0] operand_b,
   output logic [1:0]   op_sel,
   output logic         alu_start,
   output logic [W-1:0] disp_value,
   output logic         disp_neg,
   output logic         disp_error,
   output logic         busy,
   output logic [2:0]   state
);

   localparam int unsigned CW = $clog2(MAX_DIGITS + 1);
   localparam int unsigned TW = $clog2(TIMEOUT + 1);
   localparam logic [CW-1:0] MAX_CNT = CW'(MAX_DIGITS);
   localparam logic [TW-1:0] TMO_MAX = TW'(TIMEOUT);

   typedef enum logic [2:0] {
      S_ENTER_A = 3'd0,
      S_ENTER_B = 3'd1,
      S_EXEC    = 3'd2,
      S_WAIT    = 3'd3,
      S_RESULT  = 3'd4,
      S_ERROR   = 3'd5
   } state_t;

   state_t        state_q, state_d;
   logic [W-1:0]  a_q, a_d, b_q, b_d, res_q, res_d;
   logic [CW-1:0] a_cnt_q, a_cnt_d, b_cnt_q, b_cnt_d;
   logic [1:0]    op_q, op_d;
   logic          neg_q, neg_d;
   logic [TW-1:0] tmo_q, tmo_d;
   logic [W-1:0]  disp_value_q, disp_value_d;
   logic          disp_neg_q, disp_neg_d;
   logic          disp_error_q, disp_error_d;
   logic          alu_start_q, alu_start_d;
   logic          busy_q, busy_d;

   logic          k_digit, k_op, k_eq, k_clr;
   logic [1:0]    k_opcode;

   assign k_digit  = press && (key < 5'd10);
   assign k_op     = press && (key >= 5'd10) && (key <= 5'd13);
   assign k_eq     = press && (key == 5'd14);
   assign k_clr    = press && (key == 5'd15);
   // key-10 for keys 10..13: the low two bits plus 2, wrapping mod 4
   assign k_opcode = key[1:0] + 2'd2;

   // State and datapath registers, synchronous active-high reset
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q      <= S_ENTER_A;
         a_q          <= '0;
         b_q          <= '0;
         res_q        <= '0;
         a_cnt_q      <= '0;
         b_cnt_q      <= '0;
         op_q         <= '0;
         neg_q        <= 1'b0;
         tmo_q        <= '0;
         disp_value_q <= '0;
         disp_neg_q   <= 1'b0;
         disp_error_q <= 1'b0;
         alu_start_q  <= 1'b0;
         busy_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         a_q          <= a_d;
         b_q          <= b_d;
         res_q        <= res_d;
         a_cnt_q      <= a_cnt_d;
         b_cnt_q      <= b_cnt_d;
         op_q         <= op_d;
         neg_q        <= neg_d;
         tmo_q        <= tmo_d;
         disp_value_q <= disp_value_d;
         disp_neg_q   <= disp_neg_d;
         disp_error_q <= disp_error_d;
         alu_start_q  <= alu_start_d;
         busy_q       <= busy_d;
      end
   end

   // Next state plus operand, operator, result and timeout updates
   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      res_d   = res_q;
      a_cnt_d = a_cnt_q;
      b_cnt_d = b_cnt_q;
      op_d    = op_q;
      neg_d   = neg_q;
      tmo_d   = tmo_q;
      if (k_clr) begin
         state_d = S_ENTER_A;
         a_d     = '0;
         b_d     = '0;
         res_d   = '0;
         a_cnt_d = '0;
         b_cnt_d = '0;
         op_d    = '0;
         neg_d   = 1'b0;
         tmo_d   = '0;
      end else begin
         case (state_q)
            S_ENTER_A: begin
               if (k_digit) begin
                  if (a_cnt_q < MAX_CNT) begin
                     a_d     = a_q * W'(10) + W'(key);
                     a_cnt_d = a_cnt_q + CW'(1);
                  end
               end else if (k_op) begin
                  op_d    = k_opcode;
                  state_d = S_ENTER_B;
               end
            end
            S_ENTER_B: begin
               if (k_digit) begin
                  if (b_cnt_q < MAX_CNT) begin
                     b_d     = b_q * W'(10) + W'(key);
                     b_cnt_d = b_cnt_q + CW'(1);
                  end
               end else if (k_op && (b_cnt_q == '0)) begin
                  op_d = k_opcode;
               end else if (k_eq && (b_cnt_q != '0)) begin
                  state_d = S_EXEC;
               end
            end
            S_EXEC: begin
               tmo_d   = '0;
               state_d = S_WAIT;
            end
            S_WAIT: begin
               // a done pulse in the timeout cycle takes precedence
               if (alu_done) begin
                  res_d   = alu_result;
                  neg_d   = alu_neg;
                  state_d = alu_error ? S_ERROR : S_RESULT;
               end else if (tmo_q == TMO_MAX) begin
                  state_d = S_ERROR;
               end else begin
                  tmo_d = tmo_q + TW'(1);
               end
            end
            S_RESULT: begin
               if (k_digit) begin
                  a_d     = W'(key);
                  a_cnt_d = CW'(1);
                  b_d     = '0;
                  b_cnt_d = '0;
                  state_d = S_ENTER_A;
               end else if (k_op) begin
                  // chained result is locked against further digit appends
                  a_d     = res_q;
                  a_cnt_d = MAX_CNT;
                  b_d     = '0;
                  b_cnt_d = '0;
                  op_d    = k_opcode;
                  state_d = S_ENTER_B;
               end
            end
            S_ERROR: ;
            default: state_d = S_ENTER_A;
         endcase
      end
   end

   // Registered outputs decoded from the upcoming state and datapath values
   always_comb begin
      alu_start_d  = (state_d == S_EXEC);
      busy_d       = (state_d == S_EXEC) || (state_d == S_WAIT);
      disp_value_d = a_d;
      disp_neg_d   = 1'b0;
      disp_error_d = 1'b0;
      case (state_d)
         S_ENTER_A: disp_value_d = a_d;
         S_ENTER_B: disp_value_d = (b_cnt_d != '0) ? b_d : a_d;
         S_EXEC,
         S_WAIT:    disp_value_d = b_d;
         S_RESULT: begin
            disp_value_d = res_d;
            disp_neg_d   = neg_d;
         end
         S_ERROR: begin
            disp_value_d = '0;
            disp_error_d = 1'b1;
         end
         default:   disp_value_d = a_d;
      endcase
   end

   assign operand_a  = a_q;
   assign operand_b  = b_q;
   assign op_sel     = op_q;
   assign alu_start  = alu_start_q;
   assign disp_value = disp_value_q;
   assign disp_neg   = disp_neg_q;
   assign disp_error = disp_error_q;
   assign busy       = busy_q;
   assign state      = state_q;

endmodule

// File: tb/tb_calc_sequencer.sv
// Directed bench for calc_sequencer with a hand-driven ALU responder.
module tb_calc_sequencer;

   localparam int W       = 14;
   localparam int TIMEOUT = 64;

   logic         clock = 1'b0;
   logic         reset = 1'b1;
   logic [4:0]   key = '0;
   logic         press = 1'b0;
   logic         alu_done = 1'b0;
   logic         alu_error = 1'b0;
   logic         alu_neg = 1'b0;
   logic [W-1:0] alu_result = '0;
   logic [W-1:0] operand_a, operand_b, disp_value;
   logic [1:0]   op_sel;
   logic         alu_start, disp_neg, disp_error, busy;
   logic [2:0]   state;

   int checks = 0;
   int failures = 0;
   int start_cnt = 0;

   calc_sequencer #(.W(W), .MAX_DIGITS(4), .TIMEOUT(TIMEOUT)) dut (
      .clock(clock), .reset(reset), .key(key), .press(press),
      .alu_done(alu_done), .alu_error(alu_error), .alu_neg(alu_neg),
      .alu_result(alu_result), .operand_a(operand_a), .operand_b(operand_b),
      .op_sel(op_sel), .alu_start(alu_start), .disp_value(disp_value),
      .disp_neg(disp_neg), .disp_error(disp_error), .busy(busy), .state(state)
   );

   always #5 clock = ~clock;

   always @(posedge clock) if (alu_start === 1'b1) start_cnt <= start_cnt + 1;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // one key strobe sampled by a single rising edge; returns at the next negedge
   task automatic press_key(input logic [4:0] k);
      @(negedge clock);
      key = k; press = 1'b1;
      @(negedge clock);
      press = 1'b0; key = '0;
   endtask

   // wait dly negedges, then pulse alu_done for one edge
   task automatic alu_reply(input int dly, input logic [W-1:0] r, input logic e, input logic n);
      repeat (dly) @(negedge clock);
      alu_done = 1'b1; alu_result = r; alu_error = e; alu_neg = n;
      @(negedge clock);
      alu_done = 1'b0; alu_result = '0; alu_error = 1'b0; alu_neg = 1'b0;
   endtask

   task automatic check_idle(input string tag);
      check({tag, "_state"}, 32'(state), 0);
      check({tag, "_a"}, 32'(operand_a), 0);
      check({tag, "_b"}, 32'(operand_b), 0);
      check({tag, "_op"}, 32'(op_sel), 0);
      check({tag, "_disp"}, 32'(disp_value), 0);
      check({tag, "_flags"}, {28'd0, alu_start, busy, disp_neg, disp_error}, 0);
   endtask

   initial begin
      int s0;
      repeat (2) @(negedge clock);
      reset = 1'b0;
      check_idle("reset");

      // 12 + 3 = 15
      press_key(5'd1);
      press_key(5'd2);
      check("a12", 32'(operand_a), 12);
      check("disp12", 32'(disp_value), 12);
      press_key(5'd10);
      check("st_b", 32'(state), 1);
      check("op_add", 32'(op_sel), 0);
      press_key(5'd3);
      check("b3", 32'(operand_b), 3);
      check("disp3", 32'(disp_value), 3);
      press_key(5'd14);
      check("st_exec", 32'(state), 2);
      check("start_hi", 32'(alu_start), 1);
      check("busy_exec", 32'(busy), 1);
      @(negedge clock);
      check("st_wait", 32'(state), 3);
      check("start_lo", 32'(alu_start), 0);
      check("a_stable", 32'(operand_a), 12);
      alu_reply(1, 14'd15, 1'b0, 1'b0);
      check("st_result", 32'(state), 4);
      check("disp15", 32'(disp_value), 15);
      check("neg0", 32'(disp_neg), 0);
      check("busy_res", 32'(busy), 0);
      check("ops_kept", {operand_a[15:0], operand_b[15:0]}, {16'd12, 16'd3});
      check("one_start", 32'(start_cnt), 1);

      // chaining: 15 * 2 = 30, then a digit restarts entry
      press_key(5'd12);
      check("ch_state", 32'(state), 1);
      check("ch_a", 32'(operand_a), 15);
      check("ch_op", 32'(op_sel), 2);
      check("ch_disp", 32'(disp_value), 15);
      press_key(5'd2);
      check("ch_b", 32'(operand_b), 2);
      press_key(5'd14);
      alu_reply(2, 14'd30, 1'b0, 1'b1);
      check("ch_res_st", 32'(state), 4);
      check("disp30", 32'(disp_value), 30);
      check("neg1", 32'(disp_neg), 1);
      press_key(5'd7);
      check("dg_state", 32'(state), 0);
      check("dg_a", 32'(operand_a), 7);
      check("dg_b", 32'(operand_b), 0);
      check("dg_neg", 32'(disp_neg), 0);
      press_key(5'd8);
      check("dg_a78", 32'(operand_a), 78);

      // digit limit and operator replace
      press_key(5'd15);
      check_idle("clr1");
      for (int i = 0; i < 5; i++) press_key(5'd9);
      check("a9999", 32'(operand_a), 9999);
      press_key(5'd11);
      check("op_sub", 32'(op_sel), 1);
      press_key(5'd12);
      check("op_repl", 32'(op_sel), 2);
      press_key(5'd1);
      press_key(5'd10);
      check("op_nochain", 32'(op_sel), 2);
      check("nochain_st", 32'(state), 1);
      press_key(5'd15);

      // equals with empty B, then divide by zero error
      s0 = start_cnt;
      press_key(5'd5);
      press_key(5'd13);
      press_key(5'd14);
      repeat (2) @(negedge clock);
      check("eq_empty_st", 32'(state), 1);
      check("eq_empty_start", 32'(start_cnt - s0), 0);
      press_key(5'd0);
      check("b0_disp", 32'(disp_value), 0);
      press_key(5'd14);
      alu_reply(1, 14'd0, 1'b1, 1'b0);
      check("err_st", 32'(state), 5);
      check("err_flag", 32'(disp_error), 1);
      check("err_disp", 32'(disp_value), 0);
      press_key(5'd3);
      press_key(5'd10);
      check("err_hold", 32'(state), 5);
      check("err_a", 32'(operand_a), 5);
      press_key(5'd15);
      check_idle("clr_err");

      // timeout: WAIT entered after the edge following equals
      press_key(5'd1);
      press_key(5'd10);
      press_key(5'd1);
      press_key(5'd14);
      repeat (TIMEOUT + 1) @(negedge clock);
      check("tmo_still_wait", 32'(state), 3);
      @(negedge clock);
      check("tmo_err", 32'(state), 5);
      check("tmo_flag", 32'(disp_error), 1);
      press_key(5'd15);

      // clear mid-WAIT, then a late done
      press_key(5'd2);
      press_key(5'd10);
      press_key(5'd2);
      press_key(5'd14);
      repeat (3) @(negedge clock);
      press_key(5'd15);
      check("abort_st", 32'(state), 0);
      alu_reply(0, 14'd99, 1'b0, 1'b0);
      check_idle("late_done");

      // reset beats a simultaneous key press
      press_key(5'd3);
      @(negedge clock);
      reset = 1'b1; press = 1'b1; key = 5'd4;
      @(negedge clock);
      reset = 1'b0; press = 1'b0; key = '0;
      check_idle("rst_key");

      // reset during WAIT together with a done pulse
      press_key(5'd1);
      press_key(5'd10);
      press_key(5'd1);
      press_key(5'd14);
      @(negedge clock);
      s0 = start_cnt;
      reset = 1'b1; alu_done = 1'b1; alu_result = 14'd2;
      @(negedge clock);
      reset = 1'b0; alu_done = 1'b0; alu_result = '0;
      check_idle("rst_wait");
      repeat (3) @(negedge clock);
      check("rst_no_start", 32'(start_cnt - s0), 0);
      check("rst_idle_st", 32'(state), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
